mips16_mc_controller: RTL and testbench

//  Multi-cycle control FSM for the 16-bit MIPS datapath: sequences fetch/decode/execute/mem/writeback over one shared

---
 rtl/mips16_ctrl_pkg.sv | 37 +++
 rtl/mem_wait_timer.sv | 23 ++
 rtl/mips16_mc_controller.sv | 159 +++++++++++++++
 tb/tb_mips16_mc_controller.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/mips16_ctrl_pkg.sv
// Shared control encodings for the 16-bit MIPS multi-cycle controller and its datapath.
package mips16_ctrl_pkg;

   localparam int unsigned OP_W = 4;

   localparam logic [OP_W-1:0] OP_R    = 4'b0000;
   localparam logic [OP_W-1:0] OP_ADDI = 4'b0001;
   localparam logic [OP_W-1:0] OP_LW   = 4'b0010;
   localparam logic [OP_W-1:0] OP_SW   = 4'b0011;
   localparam logic [OP_W-1:0] OP_BEQ  = 4'b0100;
   localparam logic [OP_W-1:0] OP_BNE  = 4'b0101;
   localparam logic [OP_W-1:0] OP_J    = 4'b0110;
   localparam logic [OP_W-1:0] OP_HALT = 4'b1111;

   localparam logic [1:0] PC_SRC_ALU = 2'b00;
   localparam logic [1:0] PC_SRC_BR  = 2'b01;
   localparam logic [1:0] PC_SRC_JMP = 2'b10;

   localparam logic [1:0] ALU_B_RT   = 2'b00;
   localparam logic [1:0] ALU_B_ONE  = 2'b01;
   localparam logic [1:0] ALU_B_IMM  = 2'b10;
   localparam logic [1:0] ALU_B_BOFF = 2'b11;

   localparam logic [1:0] ALU_OP_ADD   = 2'b00;
   localparam logic [1:0] ALU_OP_SUB   = 2'b01;
   localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

   typedef enum logic [3:0] {
      ST_FETCH, ST_DECODE, ST_EXEC_R, ST_EXEC_I, ST_MEM_ADDR, ST_MEM_RD, ST_MEM_WR,
      ST_WB_R, ST_WB_I, ST_WB_MEM, ST_BRANCH, ST_JUMP, ST_HALT
   } state_t;

   function automatic logic is_legal_op(input logic [OP_W-1:0] op);
      return (op inside {OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_HALT});
   endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive stalled memory-request cycles and flags a timeout on the last allowed one.
module mem_wait_timer #(
   parameter int unsigned MEM_TIMEOUT = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic waiting,
   output logic timeout
);

   localparam int unsigned CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);

   logic [CW-1:0] cnt;

   // Any cycle without a stall restarts the count, so each new access starts from zero.
   always_ff @(posedge clk) begin
      if (reset || !waiting) cnt <= '0;
      else                   cnt <= cnt + CW'(1);
   end

   assign timeout = (MEM_TIMEOUT != 0) && waiting && (cnt == CW'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/mips16_mc_controller.sv
// Multi-cycle control FSM: sequences fetch/decode/execute/mem/writeback over a shared memory port.
module mips16_mc_controller #(
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter int unsigned CNT_W       = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [3:0]       opcode,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic             mem_we,
   output logic             mem_addr_sel,
   output logic             ir_write,
   output logic             pc_write,
   output logic [1:0]       pc_src,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       alu_op,
   output logic             reg_write,
   output logic             reg_dst,
   output logic             mem_to_reg,
   output logic             halted,
   output logic             illegal_op,
   output logic             bus_error,
   output logic [CNT_W-1:0] instr_count
);
   import mips16_ctrl_pkg::*;

   state_t state, next_state;
   logic   waiting_c, timeout_c, retire_c;

   assign waiting_c = mem_req & ~mem_ready;

   mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wait_timer (
      .clk     (clk),
      .reset   (reset),
      .waiting (waiting_c),
      .timeout (timeout_c)
   );

   always_ff @(posedge clk) begin
      if (reset) state <= ST_FETCH;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         ST_FETCH:    if (timeout_c) next_state = ST_HALT;
                      else if (mem_ready) next_state = ST_DECODE;
         ST_DECODE: begin
            case (opcode)
               OP_R:           next_state = ST_EXEC_R;
               OP_ADDI:        next_state = ST_EXEC_I;
               OP_LW, OP_SW:   next_state = ST_MEM_ADDR;
               OP_BEQ, OP_BNE: next_state = ST_BRANCH;
               OP_J:           next_state = ST_JUMP;
               OP_HALT:        next_state = ST_HALT;
               default:        next_state = ST_FETCH;
            endcase
         end
         ST_EXEC_R:   next_state = ST_WB_R;
         ST_EXEC_I:   next_state = ST_WB_I;
         ST_MEM_ADDR: next_state = (opcode == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
         ST_MEM_RD:   if (timeout_c) next_state = ST_HALT;
                      else if (mem_ready) next_state = ST_WB_MEM;
         ST_MEM_WR:   if (timeout_c) next_state = ST_HALT;
                      else if (mem_ready) next_state = ST_FETCH;
         ST_WB_R, ST_WB_I, ST_WB_MEM, ST_BRANCH, ST_JUMP: next_state = ST_FETCH;
         ST_HALT:     next_state = ST_HALT;
         default:     next_state = ST_FETCH;
      endcase
   end

   // Strobes are decoded from state and forced low while reset is held, so an aborted access never completes.
   always_comb begin
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr_sel = 1'b0;
      ir_write     = 1'b0;
      pc_write     = 1'b0;
      pc_src       = PC_SRC_ALU;
      alu_src_a    = 1'b0;
      alu_src_b    = ALU_B_RT;
      alu_op       = ALU_OP_ADD;
      reg_write    = 1'b0;
      reg_dst      = 1'b0;
      mem_to_reg   = 1'b0;
      halted       = 1'b0;
      illegal_op   = 1'b0;
      if (!reset) begin
         case (state)
            ST_FETCH: begin
               mem_req   = 1'b1;
               alu_src_b = ALU_B_ONE;
               ir_write  = mem_ready;
               pc_write  = mem_ready;
            end
            ST_DECODE: begin
               alu_src_b  = ALU_B_BOFF;
               illegal_op = ~is_legal_op(opcode);
            end
            ST_EXEC_R: begin
               alu_src_a = 1'b1;
               alu_op    = ALU_OP_FUNCT;
            end
            ST_EXEC_I, ST_MEM_ADDR: begin
               alu_src_a = 1'b1;
               alu_src_b = ALU_B_IMM;
            end
            ST_MEM_RD: begin
               mem_req      = 1'b1;
               mem_addr_sel = 1'b1;
            end
            ST_MEM_WR: begin
               mem_req      = 1'b1;
               mem_addr_sel = 1'b1;
               mem_we       = 1'b1;
            end
            ST_WB_R: begin
               reg_write = 1'b1;
               reg_dst   = 1'b1;
            end
            ST_WB_I:   reg_write = 1'b1;
            ST_WB_MEM: begin
               reg_write  = 1'b1;
               mem_to_reg = 1'b1;
            end
            ST_BRANCH: begin
               alu_src_a = 1'b1;
               alu_op    = ALU_OP_SUB;
               pc_src    = PC_SRC_BR;
               pc_write  = (opcode == OP_BEQ) ? zero : ~zero;
            end
            ST_JUMP: begin
               pc_write = 1'b1;
               pc_src   = PC_SRC_JMP;
            end
            ST_HALT:   halted = 1'b1;
            default: ;
         endcase
      end
   end

   assign retire_c = (state inside {ST_WB_R, ST_WB_I, ST_WB_MEM, ST_BRANCH, ST_JUMP})
                   || (state == ST_MEM_WR && mem_ready);

   always_ff @(posedge clk) begin
      if (reset) begin
         bus_error   <= 1'b0;
         instr_count <= '0;
      end else begin
         if (timeout_c) bus_error <= 1'b1;
         if (retire_c)  instr_count <= instr_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_mips16_mc_controller.sv
// Directed scoreboard bench for the multi-cycle controller: per-cycle expected control vectors.
module tb_mips16_mc_controller;
   import mips16_ctrl_pkg::*;

   typedef struct packed {
      logic        req, we, asel, irw, pcw;
      logic [1:0]  pcs;
      logic        a;
      logic [1:0]  b, op;
      logic        rw, rd, m2r, hlt, ill, berr;
      logic [15:0] cnt;
   } obs_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [3:0] opcode = 4'b0000;
   logic zero = 1'b0;
   logic mem_ready = 1'b0;
   logic mem_req, mem_we, mem_addr_sel, ir_write, pc_write, alu_src_a;
   logic [1:0] pc_src, alu_src_b, alu_op;
   logic reg_write, reg_dst, mem_to_reg, halted, illegal_op, bus_error;
   logic [15:0] instr_count;

   obs_t obs;
   obs_t sb[$];
   int compared = 0;
   int mism = 0;
   logic [15:0] exp_cnt = 16'd0;
   logic exp_berr = 1'b0;

   always #5 clk = ~clk;

   mips16_mc_controller #(.MEM_TIMEOUT(8), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .ir_write(ir_write),
      .pc_write(pc_write), .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .alu_op(alu_op), .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
      .halted(halted), .illegal_op(illegal_op), .bus_error(bus_error), .instr_count(instr_count)
   );

   assign obs = '{req: mem_req, we: mem_we, asel: mem_addr_sel, irw: ir_write, pcw: pc_write,
                  pcs: pc_src, a: alu_src_a, b: alu_src_b, op: alu_op, rw: reg_write,
                  rd: reg_dst, m2r: mem_to_reg, hlt: halted, ill: illegal_op,
                  berr: bus_error, cnt: instr_count};

   // Expected control vectors per state, straight from the control table.
   function automatic obs_t f_idle();
      obs_t r = '0;
      return r;
   endfunction
   function automatic obs_t f_fetch(input logic rdy);
      obs_t r = '0;
      r.req = 1'b1; r.b = 2'b01; r.irw = rdy; r.pcw = rdy;
      return r;
   endfunction
   function automatic obs_t f_decode(input logic ill);
      obs_t r = '0;
      r.b = 2'b11; r.ill = ill;
      return r;
   endfunction
   function automatic obs_t f_exec_r();
      obs_t r = '0;
      r.a = 1'b1; r.op = 2'b10;
      return r;
   endfunction
   function automatic obs_t f_exec_imm();
      obs_t r = '0;
      r.a = 1'b1; r.b = 2'b10;
      return r;
   endfunction
   function automatic obs_t f_mem(input logic we);
      obs_t r = '0;
      r.req = 1'b1; r.asel = 1'b1; r.we = we;
      return r;
   endfunction
   function automatic obs_t f_wb(input logic rd, input logic m2r);
      obs_t r = '0;
      r.rw = 1'b1; r.rd = rd; r.m2r = m2r;
      return r;
   endfunction
   function automatic obs_t f_branch(input logic pcw);
      obs_t r = '0;
      r.a = 1'b1; r.op = 2'b01; r.pcs = 2'b01; r.pcw = pcw;
      return r;
   endfunction
   function automatic obs_t f_jump();
      obs_t r = '0;
      r.pcw = 1'b1; r.pcs = 2'b10;
      return r;
   endfunction
   function automatic obs_t f_halt();
      obs_t r = '0;
      r.hlt = 1'b1;
      return r;
   endfunction

   task automatic step(input string tag, input logic rst, input logic [3:0] op,
                       input logic z, input logic rdy, input obs_t e);
      obs_t want;
      @(negedge clk);
      reset = rst; opcode = op; zero = z; mem_ready = rdy;
      e.cnt = exp_cnt;
      e.berr = exp_berr;
      sb.push_back(e);
      #1;
      want = sb.pop_front();
      compared++;
      assert (obs === want) else begin
         mism++;
         $error("FAIL %s: observed %h expected %h", tag, obs, want);
      end
   endtask

   task automatic retire();
      exp_cnt = exp_cnt + 16'd1;
   endtask

   initial begin
      // Reset held for two cycles
      step("rst0", 1'b1, OP_R, 1'b0, 1'b1, f_idle());
      step("rst1", 1'b1, OP_R, 1'b0, 1'b1, f_idle());

      // R-type, zero-wait: 4 cycles
      step("r_fetch", 1'b0, OP_R, 1'b0, 1'b1, f_fetch(1'b1));
      step("r_decode", 1'b0, OP_R, 1'b0, 1'b0, f_decode(1'b0));
      step("r_exec", 1'b0, OP_R, 1'b0, 1'b0, f_exec_r());
      step("r_wb", 1'b0, OP_R, 1'b0, 1'b1, f_wb(1'b1, 1'b0));
      retire();

      // LW with three wait cycles in MEM_RD: 8 cycles
      step("lw_fetch", 1'b0, OP_LW, 1'b0, 1'b1, f_fetch(1'b1));
      step("lw_decode", 1'b0, OP_LW, 1'b0, 1'b1, f_decode(1'b0));
      step("lw_addr", 1'b0, OP_LW, 1'b0, 1'b1, f_exec_imm());
      for (int i = 0; i < 3; i++) step("lw_wait", 1'b0, OP_LW, 1'b0, 1'b0, f_mem(1'b0));
      step("lw_rd", 1'b0, OP_LW, 1'b0, 1'b1, f_mem(1'b0));
      step("lw_wb", 1'b0, OP_LW, 1'b0, 1'b1, f_wb(1'b0, 1'b1));
      retire();

      // Branches: BEQ/BNE with both zero values
      step("beq1_fetch", 1'b0, OP_BEQ, 1'b1, 1'b1, f_fetch(1'b1));
      step("beq1_decode", 1'b0, OP_BEQ, 1'b1, 1'b1, f_decode(1'b0));
      step("beq1_br", 1'b0, OP_BEQ, 1'b1, 1'b1, f_branch(1'b1));
      retire();
      step("beq0_fetch", 1'b0, OP_BEQ, 1'b0, 1'b1, f_fetch(1'b1));
      step("beq0_decode", 1'b0, OP_BEQ, 1'b0, 1'b1, f_decode(1'b0));
      step("beq0_br", 1'b0, OP_BEQ, 1'b0, 1'b1, f_branch(1'b0));
      retire();
      step("bne0_fetch", 1'b0, OP_BNE, 1'b0, 1'b1, f_fetch(1'b1));
      step("bne0_decode", 1'b0, OP_BNE, 1'b0, 1'b1, f_decode(1'b0));
      step("bne0_br", 1'b0, OP_BNE, 1'b0, 1'b1, f_branch(1'b1));
      retire();
      step("bne1_fetch", 1'b0, OP_BNE, 1'b1, 1'b1, f_fetch(1'b1));
      step("bne1_decode", 1'b0, OP_BNE, 1'b1, 1'b1, f_decode(1'b0));
      step("bne1_br", 1'b0, OP_BNE, 1'b1, 1'b1, f_branch(1'b0));
      retire();

      // Jump and ADDI
      step("j_fetch", 1'b0, OP_J, 1'b0, 1'b1, f_fetch(1'b1));
      step("j_decode", 1'b0, OP_J, 1'b0, 1'b1, f_decode(1'b0));
      step("j_jump", 1'b0, OP_J, 1'b0, 1'b1, f_jump());
      retire();
      step("addi_fetch", 1'b0, OP_ADDI, 1'b0, 1'b1, f_fetch(1'b1));
      step("addi_decode", 1'b0, OP_ADDI, 1'b0, 1'b1, f_decode(1'b0));
      step("addi_exec", 1'b0, OP_ADDI, 1'b0, 1'b1, f_exec_imm());
      step("addi_wb", 1'b0, OP_ADDI, 1'b0, 1'b1, f_wb(1'b0, 1'b0));
      retire();

      // SW with one wait cycle; retires on the ready cycle
      step("sw_fetch", 1'b0, OP_SW, 1'b0, 1'b1, f_fetch(1'b1));
      step("sw_decode", 1'b0, OP_SW, 1'b0, 1'b1, f_decode(1'b0));
      step("sw_addr", 1'b0, OP_SW, 1'b0, 1'b1, f_exec_imm());
      step("sw_wait", 1'b0, OP_SW, 1'b0, 1'b0, f_mem(1'b1));
      step("sw_wr", 1'b0, OP_SW, 1'b0, 1'b1, f_mem(1'b1));
      retire();

      // Illegal opcode: single-cycle pulse, back to FETCH, count unchanged
      step("ill_fetch", 1'b0, 4'b1010, 1'b0, 1'b1, f_fetch(1'b1));
      step("ill_decode", 1'b0, 4'b1010, 1'b0, 1'b1, f_decode(1'b1));
      step("ill_after", 1'b0, 4'b1010, 1'b0, 1'b0, f_fetch(1'b0));
      step("ill_after2", 1'b0, 4'b1010, 1'b0, 1'b0, f_fetch(1'b0));

      // Reset during MEM_WR aborts the write, even with mem_ready high
      step("rsw_fetch", 1'b0, OP_SW, 1'b0, 1'b1, f_fetch(1'b1));
      step("rsw_decode", 1'b0, OP_SW, 1'b0, 1'b1, f_decode(1'b0));
      step("rsw_addr", 1'b0, OP_SW, 1'b0, 1'b1, f_exec_imm());
      step("rsw_wait", 1'b0, OP_SW, 1'b0, 1'b0, f_mem(1'b1));
      step("rsw_reset", 1'b1, OP_SW, 1'b0, 1'b1, f_idle());
      exp_cnt = 16'd0;
      step("rsw_refetch", 1'b0, OP_HALT, 1'b0, 1'b1, f_fetch(1'b1));

      // HALT opcode: stays halted regardless of mem_ready
      step("halt_decode", 1'b0, OP_HALT, 1'b0, 1'b1, f_decode(1'b0));
      for (int i = 0; i < 3; i++) step("halt_hold", 1'b0, OP_R, 1'b0, 1'b1, f_halt());
      step("halt_reset", 1'b1, OP_R, 1'b0, 1'b0, f_idle());

      // Fetch timeout after 8 stalled cycles
      for (int i = 0; i < 8; i++) step("to_wait", 1'b0, OP_R, 1'b0, 1'b0, f_fetch(1'b0));
      exp_berr = 1'b1;
      step("to_halt", 1'b0, OP_R, 1'b0, 1'b0, f_halt());
      step("to_halt_rdy", 1'b0, OP_R, 1'b0, 1'b1, f_halt());
      step("to_halt_hold", 1'b0, OP_R, 1'b0, 1'b0, f_halt());
      step("to_reset", 1'b1, OP_R, 1'b0, 1'b0, f_idle());
      exp_berr = 1'b0;
      step("to_clear", 1'b0, OP_R, 1'b0, 1'b0, f_fetch(1'b0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
      $finish;
   end

endmodule
